// File: rtl/arbiter_rr_ffs.sv
// ---------------------------------------------------------------------------
// arbiter_rr_ffs
//   Round-robin arbiter that shares one downstream resource between CLIENTS
//   requesters. A grant is registered and held until the granted client
//   acknowledges it. On the acknowledge edge the arbiter immediately picks the
//   next winner, so grants can follow each other without an idle cycle.
//
//   The winner is picked with two find-first-set searches:
//   - one over the requests strictly above the last served client;
//   - one over the raw request vector, used when the first search is empty.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_block_arb  suppresses new grants (an active grant is kept)
//   i_req        level-sensitive request vector, one bit per client
//   i_gnt_ack    acknowledge vector; only the granted client's bit matters
//   o_gnt_valid  a grant is active
//   o_gnt        one-hot grant, zero when no grant is active
//   o_gnt_id     binary index of the granted client
// ---------------------------------------------------------------------------
module arbiter_rr_ffs #(
  parameter int CLIENTS       = 8,
  parameter     INSTANCE_NAME = "ARB",
  localparam int IDW          = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_block_arb,
  input  logic [CLIENTS-1:0] i_req,
  input  logic [CLIENTS-1:0] i_gnt_ack,
  output logic               o_gnt_valid,
  output logic [CLIENTS-1:0] o_gnt,
  output logic [IDW-1:0]     o_gnt_id
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state;
  logic [IDW-1:0]     r_last;

  logic [IDW-1:0]     base;
  logic [CLIENTS-1:0] mask;
  logic [CLIENTS-1:0] masked;
  logic [IDW:0]       ffs_masked;
  logic [IDW:0]       ffs_raw;
  logic [IDW-1:0]     winner;
  logic [CLIENTS-1:0] gnt_next;
  logic               arb_ok;
  logic               ack_ok;

  // The label is for debug only; folding it into a dummy signal keeps it
  // referenced without giving it any functional effect.
  logic unused_name;
  assign unused_name = ^INSTANCE_NAME;

  // Returns {found, index} of the lowest set bit. Scanning from the top down
  // lets the lowest set bit overwrite any higher one.
  function automatic logic [IDW:0] find_first_set(input logic [CLIENTS-1:0] vec);
    logic [IDW:0] res;
    res = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, IDW'(i)};
      end
    end
    return res;
  endfunction

  // Winner selection. In GRANT the arbitration only matters on the ack edge,
  // where the priority base is the client being acknowledged right now
  // (r_last still holds the previous one at that point).
  always_comb begin
    base = (state == GRANT) ? o_gnt_id : r_last;
    mask = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      mask[i] = (i > int'(base));
    end
    masked     = i_req & mask;
    ffs_masked = find_first_set(masked);
    ffs_raw    = find_first_set(i_req);
    winner     = ffs_masked[IDW] ? ffs_masked[IDW-1:0] : ffs_raw[IDW-1:0];
    gnt_next   = '0;
    gnt_next[winner] = 1'b1;
    arb_ok     = !i_block_arb && (i_req != '0);
    ack_ok     = i_gnt_ack[o_gnt_id];
  end

  // Grant FSM with registered outputs. r_last moves only on reset or on an
  // honoured acknowledge, which is what makes the rotation fair.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      r_last      <= IDW'(CLIENTS - 1);
      o_gnt_valid <= 1'b0;
      o_gnt       <= '0;
      o_gnt_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_ok) begin
            state       <= GRANT;
            o_gnt_valid <= 1'b1;
            o_gnt       <= gnt_next;
            o_gnt_id    <= winner;
          end
        end
        GRANT: begin
          if (ack_ok) begin
            r_last <= o_gnt_id;
            if (arb_ok) begin
              o_gnt_valid <= 1'b1;
              o_gnt       <= gnt_next;
              o_gnt_id    <= winner;
            end else begin
              state       <= IDLE;
              o_gnt_valid <= 1'b0;
              o_gnt       <= '0;
              o_gnt_id    <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          o_gnt_valid <= 1'b0;
          o_gnt       <= '0;
          o_gnt_id    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_rr_ffs.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_ffs
//   Self-checking bench for arbiter_rr_ffs with CLIENTS=4. A directed sequence
//   walks through reset, back-to-back rotation, wrap-around, held grants,
//   blocking and reset during a grant, followed by a randomized phase. Every
//   cycle the DUT outputs are compared against a behavioural model that
//   serves clients in rotating order starting just after the last served one.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_ffs;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         blockArb;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic         gntValid;
  logic [N-1:0] gnt;
  logic [1:0]   gntId;

  int tests    = 0;
  int failures = 0;

  // Reference model state
  bit mValid;
  int mId;
  int mLast;

  arbiter_rr_ffs #(
    .CLIENTS(N),
    .INSTANCE_NAME("TB_ARB")
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_block_arb(blockArb),
    .i_req      (req),
    .i_gnt_ack  (ack),
    .o_gnt_valid(gntValid),
    .o_gnt      (gnt),
    .o_gnt_id   (gntId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next client in rotation after 'last' with an active request; 'last'
  // itself is visited only after every other client.
  function automatic int pickNext(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic stepModel(input bit r, input bit b, input logic [N-1:0] rq,
                           input logic [N-1:0] ak);
    if (r) begin
      mValid = 0;
      mId    = 0;
      mLast  = N - 1;
    end else if (!mValid) begin
      if (!b && rq != 0) begin
        mValid = 1;
        mId    = pickNext(mLast, rq);
      end
    end else if (ak[mId]) begin
      mLast = mId;
      if (!b && rq != 0) begin
        mId = pickNext(mId, rq);
      end else begin
        mValid = 0;
        mId    = 0;
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [N-1:0] expGnt;
    expGnt = mValid ? (N'(1) << mId) : '0;
    checkValue({tag, ".valid"}, 32'(gntValid), 32'(mValid));
    checkValue({tag, ".gnt"},   32'(gnt),      32'(expGnt));
    checkValue({tag, ".id"},    32'(gntId),    32'(mId));
  endtask

  // Drives one cycle of inputs away from the active edge, advances the model
  // on the edge, and checks outputs shortly after it.
  task automatic applyStimulus(input bit r, input bit b, input logic [N-1:0] rq,
                               input logic [N-1:0] ak, input string tag);
    @(negedge clk);
    rst      = r;
    blockArb = b;
    req      = rq;
    ack      = ak;
    @(posedge clk);
    stepModel(r, b, rq, ak);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] ak;
    bit           r;
    bit           b;

    rst = 1'b1; blockArb = 1'b0; req = '0; ack = '0;
    mValid = 0; mId = 0; mLast = N - 1;

    // Reset with all requests pending, then first grant goes to client 0
    applyStimulus(1, 0, 4'hF, 4'h0, "rst0");
    checkValue("rst0.valid_const", 32'(gntValid), 32'd0);
    applyStimulus(1, 0, 4'hF, 4'h0, "rst1");
    checkValue("rst1.gnt_const", 32'(gnt), 32'd0);
    applyStimulus(0, 0, 4'hF, 4'h0, "first");
    checkValue("first.id_const", 32'(gntId), 32'd0);

    // Back-to-back rotation 0 -> 1 -> 2 -> 3 -> 0 with prompt acks
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 4'hF, N'(1) << mId, "rot");
      checkValue("rot.id_const", 32'(gntId), 32'(i % 4));
      checkValue("rot.valid_const", 32'(gntValid), 32'd1);
    end

    // Wrap-around: grant 1, then req 1010 gives 3, then 1 again
    applyStimulus(0, 0, 4'b0010, 4'b0001, "wrap_g1");
    checkValue("wrap_g1.id_const", 32'(gntId), 32'd1);
    applyStimulus(0, 0, 4'b1010, 4'b0010, "wrap_g3");
    checkValue("wrap_g3.id_const", 32'(gntId), 32'd3);
    applyStimulus(0, 0, 4'b1010, 4'b1000, "wrap_g1b");
    checkValue("wrap_g1b.id_const", 32'(gntId), 32'd1);

    // Held grant: client 2 granted, requests dropped, wrong ack ignored
    applyStimulus(0, 0, 4'b0100, 4'b0010, "hold_g2");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 4'b0000, 4'b0000, "hold");
      checkValue("hold.gnt_const", 32'(gnt), 32'h4);
    end
    applyStimulus(0, 0, 4'b0000, 4'b0001, "hold_wrongack");
    checkValue("hold_wrongack.gnt_const", 32'(gnt), 32'h4);
    applyStimulus(0, 0, 4'b0000, 4'b0100, "hold_release");
    checkValue("hold_release.valid_const", 32'(gntValid), 32'd0);

    // Blocking keeps the arbiter idle; grant follows one edge after release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0001, 4'b0000, "block");
      checkValue("block.valid_const", 32'(gntValid), 32'd0);
    end
    applyStimulus(0, 0, 4'b0001, 4'b0000, "unblock");
    checkValue("unblock.gnt_const", 32'(gnt), 32'h1);

    // Reset while client 3 is granted
    applyStimulus(0, 0, 4'b1000, 4'b0001, "pre_rst_g3");
    checkValue("pre_rst_g3.id_const", 32'(gntId), 32'd3);
    applyStimulus(1, 0, 4'hF, 4'h0, "mid_rst");
    checkValue("mid_rst.gnt_const", 32'(gnt), 32'd0);
    applyStimulus(0, 0, 4'hF, 4'h0, "post_rst");
    checkValue("post_rst.id_const", 32'(gntId), 32'd0);

    // Randomized phase against the model
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      b  = ($urandom_range(0, 7) == 0);
      rq = N'($urandom);
      ak = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      if ($urandom_range(0, 2) != 0 && mValid) ak = ak | (N'(1) << mId);
      applyStimulus(r, b, rq, ak, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
